// File: rtl/ucsbece154a_multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I-subset datapath with a shared, ready-handshaked memory.
// Drives every datapath select and enable; ALU and immediate decode come from the IR fields.
module ucsbece154a_multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       Zero_i,
    input  logic       MemReady_i,
    output logic       PCWrite_o,
    output logic       AdrSrc_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic [1:0] ResultSrc_o,
    output logic [1:0] ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [2:0] ImmSrc_o,
    output logic [2:0] ALUControl_o,
    output logic       RegWrite_o,
    output logic       Error_o
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_LUI, S_ERROR
    } state_t;

    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} alu_op_t;

    state_t  state, state_n;
    alu_op_t alu_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_FETCH:    if (MemReady_i) state_n = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_R:         state_n = S_EXECUTER;
                    OP_I:         state_n = S_EXECUTEI;
                    OP_BEQ:       state_n = S_BEQ;
                    OP_JAL:       state_n = S_JAL;
                    OP_LUI:       state_n = S_LUI;
                    default:      state_n = S_ERROR;
                endcase
            end
            S_MEMADR:   state_n = (op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (MemReady_i) state_n = S_MEMWB;
            S_MEMWB:    state_n = S_FETCH;
            S_MEMWRITE: if (MemReady_i) state_n = S_FETCH;
            S_EXECUTER: state_n = S_ALUWB;
            S_EXECUTEI: state_n = S_ALUWB;
            S_ALUWB:    state_n = S_FETCH;
            S_BEQ:      state_n = S_FETCH;
            S_JAL:      state_n = S_ALUWB;
            S_LUI:      state_n = S_FETCH;
            S_ERROR:    state_n = S_ERROR;
            default:    state_n = S_ERROR;
        endcase
    end

    // Moore outputs; enables are forced low while reset is held.
    always_comb begin
        PCWrite_o   = 1'b0;
        AdrSrc_o    = 1'b0;
        MemWrite_o  = 1'b0;
        IRWrite_o   = 1'b0;
        ResultSrc_o = 2'b00;
        ALUSrcA_o   = 2'b00;
        ALUSrcB_o   = 2'b00;
        RegWrite_o  = 1'b0;
        Error_o     = 1'b0;
        alu_op      = ALUOP_ADD;
        unique case (state)
            S_FETCH: begin
                ALUSrcB_o   = 2'b10;
                ResultSrc_o = 2'b10;
                IRWrite_o   = MemReady_i;
                PCWrite_o   = MemReady_i;
            end
            S_DECODE: begin
                ALUSrcA_o = 2'b01;
                ALUSrcB_o = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA_o = 2'b10;
                ALUSrcB_o = 2'b01;
            end
            S_MEMREAD:  AdrSrc_o = 1'b1;
            S_MEMWB: begin
                ResultSrc_o = 2'b01;
                RegWrite_o  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc_o   = 1'b1;
                MemWrite_o = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA_o = 2'b10;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA_o = 2'b10;
                ALUSrcB_o = 2'b01;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB:    RegWrite_o = 1'b1;
            S_BEQ: begin
                ALUSrcA_o = 2'b10;
                alu_op    = ALUOP_SUB;
                PCWrite_o = Zero_i;
            end
            S_JAL: begin
                ALUSrcA_o = 2'b01;
                ALUSrcB_o = 2'b10;
                PCWrite_o = 1'b1;
            end
            S_LUI: begin
                ResultSrc_o = 2'b11;
                RegWrite_o  = 1'b1;
            end
            S_ERROR:    Error_o = 1'b1;
            default:    Error_o = 1'b1;
        endcase
        if (reset) begin
            PCWrite_o  = 1'b0;
            MemWrite_o = 1'b0;
            IRWrite_o  = 1'b0;
            RegWrite_o = 1'b0;
            Error_o    = 1'b0;
        end
    end

    // Only R-type (op[5]=1) with funct7b5 subtracts; addi ignores instr[30].
    always_comb begin
        ALUControl_o = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: ALUControl_o = ALU_ADD;
            ALUOP_SUB: ALUControl_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000:  ALUControl_o = (funct7b5_i & op_i[5]) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl_o = ALU_SLT;
                    3'b110:  ALUControl_o = ALU_OR;
                    3'b111:  ALUControl_o = ALU_AND;
                    default: ALUControl_o = 3'bxxx;
                endcase
            end
            default:   ALUControl_o = 3'bxxx;
        endcase
    end

    always_comb begin
        case (op_i)
            OP_LW, OP_I: ImmSrc_o = 3'b000;
            OP_SW:       ImmSrc_o = 3'b001;
            OP_BEQ:      ImmSrc_o = 3'b010;
            OP_JAL:      ImmSrc_o = 3'b011;
            OP_LUI:      ImmSrc_o = 3'b100;
            default:     ImmSrc_o = 3'bxxx;
        endcase
    end

endmodule

// File: tb/tb_ucsbece154a_multicycle_controller.sv
// Directed bench for the multicycle controller: per-instruction cycle schedules built from
// the instruction's class, checked every cycle, plus literal spot checks on latency and flags.
module tb_ucsbece154a_multicycle_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_BAD = 7'h7F;

    localparam logic [2:0] A_ADD = 3'b000;
    localparam logic [2:0] A_SUB = 3'b001;
    localparam logic [2:0] A_AND = 3'b010;
    localparam logic [2:0] A_OR  = 3'b011;
    localparam logic [2:0] A_SLT = 3'b101;

    typedef struct packed {
        logic       pcw, adr, memw, irw;
        logic [1:0] res, sa, sb;
        logic       regw, err;
        logic       chk_alu;
        logic [2:0] alu;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op_i = '0;
    logic [2:0] funct3_i = '0;
    logic       funct7b5_i = 1'b0;
    logic       Zero_i = 1'b0;
    logic       MemReady_i = 1'b0;
    logic       PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, RegWrite_o, Error_o;
    logic [1:0] ResultSrc_o, ALUSrcA_o, ALUSrcB_o;
    logic [2:0] ImmSrc_o, ALUControl_o;

    ucsbece154a_multicycle_controller dut (
        .clk(clk), .reset(reset), .op_i(op_i), .funct3_i(funct3_i), .funct7b5_i(funct7b5_i),
        .Zero_i(Zero_i), .MemReady_i(MemReady_i), .PCWrite_o(PCWrite_o), .AdrSrc_o(AdrSrc_o),
        .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o), .ResultSrc_o(ResultSrc_o),
        .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ImmSrc_o(ImmSrc_o),
        .ALUControl_o(ALUControl_o), .RegWrite_o(RegWrite_o), .Error_o(Error_o)
    );

    always #5 clk = ~clk;

    int    vectors = 0;
    int    miscompares = 0;
    exp_t  exp_r;
    logic  exp_valid = 1'b0;
    logic  imm_chk;
    logic [2:0] imm_req;
    string tag = "reset";
    logic  cur_rst = 1'b1;
    logic [6:0] cur_op = '0;
    logic [2:0] cur_f3 = '0;
    logic  cur_f7 = 1'b0;
    logic  cur_z = 1'b0;

    function automatic exp_t mk(input logic pcw, adr, memw, irw, input logic [1:0] res, sa, sb,
                                input logic regw, err, chk, input logic [2:0] alu);
        exp_t e;
        e.pcw = pcw; e.adr = adr; e.memw = memw; e.irw = irw;
        e.res = res; e.sa = sa; e.sb = sb; e.regw = regw; e.err = err;
        e.chk_alu = chk; e.alu = alu;
        return e;
    endfunction

    // Immediate format by instruction class; R-type and illegal ops have no defined format.
    function automatic logic [3:0] model_imm(input logic [6:0] op);
        case (op)
            OP_LW, OP_I: return {1'b1, 3'd0};
            OP_SW:       return {1'b1, 3'd1};
            OP_BEQ:      return {1'b1, 3'd2};
            OP_JAL:      return {1'b1, 3'd3};
            OP_LUI:      return {1'b1, 3'd4};
            default:     return 4'b0000;
        endcase
    endfunction

    // ALU function for arithmetic instructions: only R-type with instr[30] subtracts.
    function automatic logic [3:0] model_funct(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return {1'b1, (f7 && op == OP_R) ? A_SUB : A_ADD};
            3'd2:    return {1'b1, A_SLT};
            3'd6:    return {1'b1, A_OR};
            3'd7:    return {1'b1, A_AND};
            default: return 4'b0000;
        endcase
    endfunction

    function automatic int latency(input logic [6:0] op);
        case (op)
            OP_LW:          return 5;
            OP_SW:          return 4;
            OP_R, OP_I:     return 4;
            OP_BEQ:         return 3;
            OP_JAL:         return 4;
            OP_LUI:         return 3;
            default:        return 0;
        endcase
    endfunction

    function automatic exp_t e_fetch(input logic r); return mk(r,0,0,r,2'b10,2'b00,2'b10,0,0,1,A_ADD); endfunction
    function automatic exp_t e_decode();  return mk(0,0,0,0,2'b00,2'b01,2'b01,0,0,1,A_ADD); endfunction
    function automatic exp_t e_memadr();  return mk(0,0,0,0,2'b00,2'b10,2'b01,0,0,1,A_ADD); endfunction
    function automatic exp_t e_memread(); return mk(0,1,0,0,2'b00,2'b00,2'b00,0,0,0,A_ADD); endfunction
    function automatic exp_t e_memwb();   return mk(0,0,0,0,2'b01,2'b00,2'b00,1,0,0,A_ADD); endfunction
    function automatic exp_t e_memwr();   return mk(0,1,1,0,2'b00,2'b00,2'b00,0,0,0,A_ADD); endfunction
    function automatic exp_t e_aluwb();   return mk(0,0,0,0,2'b00,2'b00,2'b00,1,0,0,A_ADD); endfunction
    function automatic exp_t e_beq(input logic z); return mk(z,0,0,0,2'b00,2'b10,2'b00,0,0,1,A_SUB); endfunction
    function automatic exp_t e_jal();     return mk(1,0,0,0,2'b00,2'b01,2'b10,0,0,1,A_ADD); endfunction
    function automatic exp_t e_lui();     return mk(0,0,0,0,2'b11,2'b00,2'b00,1,0,0,A_ADD); endfunction
    function automatic exp_t e_err();     return mk(0,0,0,0,2'b00,2'b00,2'b00,0,1,0,A_ADD); endfunction

    // Apply one cycle of inputs at the falling edge and publish its expectation.
    task automatic cyc(input exp_t e, input logic ready);
        @(negedge clk);
        reset = cur_rst; op_i = cur_op; funct3_i = cur_f3; funct7b5_i = cur_f7;
        Zero_i = cur_z; MemReady_i = ready;
        {imm_chk, imm_req} = model_imm(cur_op);
        exp_r = e;
        exp_valid = 1'b1;
    endtask

    task automatic check_lit(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        logic [12:0] act, req;
        logic ok;
        #2;
        if (exp_valid) begin
            act = {PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, ResultSrc_o, ALUSrcA_o, ALUSrcB_o,
                   RegWrite_o, Error_o};
            req = {exp_r.pcw, exp_r.adr, exp_r.memw, exp_r.irw, exp_r.res, exp_r.sa, exp_r.sb,
                   exp_r.regw, exp_r.err};
            ok = (act === req);
            if (exp_r.chk_alu && ALUControl_o !== exp_r.alu) ok = 1'b0;
            if (imm_chk && ImmSrc_o !== imm_req) ok = 1'b0;
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL %s @%0t: pcw,adr,mw,irw,res,sa,sb,rw,err=%b alu=%b imm=%b; required %b alu=%b(chk %b) imm=%b(chk %b)",
                         tag, $time, act, ALUControl_o, ImmSrc_o, req, exp_r.alu, exp_r.chk_alu,
                         imm_req, imm_chk);
            end
        end
    end

    task automatic do_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input logic z, input int fw, input int mw);
        int n;
        logic [3:0] fa;
        exp_t ex;
        n = 0;
        tag = name; cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_z = z;
        fa = model_funct(op, f3, f7);
        for (int i = 0; i < fw; i++) begin cyc(e_fetch(1'b0), 1'b0); n++; end
        cyc(e_fetch(1'b1), 1'b1); n++;
        cyc(e_decode(), 1'b1); n++;
        case (op)
            OP_LW: begin
                cyc(e_memadr(), 1'b1); n++;
                for (int i = 0; i < mw; i++) begin cyc(e_memread(), 1'b0); n++; end
                cyc(e_memread(), 1'b1); n++;
                cyc(e_memwb(), 1'b1); n++;
            end
            OP_SW: begin
                cyc(e_memadr(), 1'b1); n++;
                for (int i = 0; i < mw; i++) begin cyc(e_memwr(), 1'b0); n++; end
                cyc(e_memwr(), 1'b1); n++;
            end
            OP_R, OP_I: begin
                ex = mk(0,0,0,0,2'b00,2'b10,(op == OP_I) ? 2'b01 : 2'b00,0,0,fa[3],fa[2:0]);
                cyc(ex, 1'b1); n++;
                cyc(e_aluwb(), 1'b1); n++;
            end
            OP_BEQ: begin cyc(e_beq(z), 1'b1); n++; end
            OP_JAL: begin
                cyc(e_jal(), 1'b1); n++;
                cyc(e_aluwb(), 1'b1); n++;
            end
            OP_LUI: begin cyc(e_lui(), 1'b1); n++; end
            default: ;
        endcase
        check_lit({name, " latency"}, n, latency(op) + fw + mw);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with memory ready: enables must stay low.
        cur_rst = 1'b1; tag = "reset hold";
        cyc(e_fetch(1'b0), 1'b1);
        cyc(e_fetch(1'b0), 1'b1);
        #3 check_lit("reset IRWrite", int'(IRWrite_o), 0);
        check_lit("reset Error", int'(Error_o), 0);
        cur_rst = 1'b0;

        do_instr("lw",           OP_LW,  3'd2, 1'b0, 1'b0, 0, 0);
        #3 check_lit("lw ResultSrc in wb", int'(ResultSrc_o), 1);
        do_instr("lw waits",     OP_LW,  3'd2, 1'b0, 1'b0, 2, 2);
        do_instr("sw wait3",     OP_SW,  3'd2, 1'b0, 1'b0, 0, 3);
        do_instr("beq taken",    OP_BEQ, 3'd0, 1'b0, 1'b1, 0, 0);
        #3 check_lit("beq ALUControl", int'(ALUControl_o), 1);
        check_lit("beq PCWrite", int'(PCWrite_o), 1);
        do_instr("beq not",      OP_BEQ, 3'd0, 1'b0, 1'b0, 0, 0);
        do_instr("R sub",        OP_R,   3'd0, 1'b1, 1'b0, 0, 0);
        do_instr("I addi f7",    OP_I,   3'd0, 1'b1, 1'b0, 0, 0);
        do_instr("R or",         OP_R,   3'd6, 1'b0, 1'b0, 1, 0);
        do_instr("I slti",       OP_I,   3'd2, 1'b0, 1'b0, 0, 0);
        do_instr("R and",        OP_R,   3'd7, 1'b0, 1'b0, 0, 0);
        do_instr("R add",        OP_R,   3'd0, 1'b0, 1'b0, 0, 0);

        // Reset in the middle of a stalled store.
        tag = "sw reset"; cur_op = OP_SW; cur_f3 = 3'd2; cur_f7 = 1'b0; cur_z = 1'b0;
        cyc(e_fetch(1'b1), 1'b1);
        cyc(e_decode(), 1'b1);
        cyc(e_memadr(), 1'b1);
        cyc(e_memwr(), 1'b0);
        #3 check_lit("memwrite before reset", int'(MemWrite_o), 1);
        cur_rst = 1'b1; tag = "sw in reset";
        cyc(e_fetch(1'b0), 1'b0);
        #3 check_lit("reset kills MemWrite", int'(MemWrite_o), 0);
        cyc(e_fetch(1'b0), 1'b1);
        cur_rst = 1'b0; tag = "sw after reset";
        cyc(e_fetch(1'b0), 1'b0);
        cyc(e_fetch(1'b1), 1'b1);
        #3 check_lit("IRWrite after reset", int'(IRWrite_o), 1);
        cyc(e_decode(), 1'b1);
        cyc(e_memadr(), 1'b1);
        cyc(e_memwr(), 1'b1);

        do_instr("jal",          OP_JAL, 3'd0, 1'b0, 1'b0, 0, 0);
        do_instr("lui",          OP_LUI, 3'd0, 1'b0, 1'b0, 0, 0);
        #3 check_lit("lui ImmSrc", int'(ImmSrc_o), 4);

        // Illegal opcode: absorbing error until reset.
        tag = "illegal"; cur_op = OP_BAD; cur_f3 = 3'd0; cur_f7 = 1'b0; cur_z = 1'b1;
        cyc(e_fetch(1'b1), 1'b1);
        cyc(e_decode(), 1'b1);
        for (int i = 0; i < 4; i++) cyc(e_err(), 1'b1);
        #3 check_lit("Error sticky", int'(Error_o), 1);
        cur_rst = 1'b1; tag = "error reset";
        cyc(e_fetch(1'b0), 1'b1);
        #3 check_lit("Error cleared by reset", int'(Error_o), 0);
        cur_rst = 1'b0;
        do_instr("lui after err", OP_LUI, 3'd0, 1'b0, 1'b0, 0, 0);

        #4 exp_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
